// File: rtl/k_fft_pkg.sv
// rtl/k_fft_pkg.sv - shared types and helpers for the FFT frame scheduler
package k_fft_pkg;

  // One complex sample: {re[63:32], im[31:0]}, each an IEEE-754 single
  typedef logic [63:0] sample_t;

  // Input-side scheduler states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } sched_state_e;

  // FFT config word: 2 scale bits per radix-4 stage plus the direction bit
  function automatic int cfg_width(input int stage_no);
    return 2 * stage_no + 1;
  endfunction

endpackage

// File: rtl/k_fft_id_fifo.sv
// rtl/k_fft_id_fifo.sv - requester-id FIFO tracking frames outstanding in the FFT
module k_fft_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Guard both ends so a stray push on full or pop on empty cannot corrupt state
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/k_fft_frame_sched.sv
// rtl/k_fft_frame_sched.sv - two-requester frame scheduler in front of a shared FFT core
module k_fft_frame_sched
  import k_fft_pkg::*;
#(
  parameter int STAGE_NO   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [127:0]                   s_axis_data_tdata,
  input  logic [1:0]                     s_axis_data_tvalid,
  output logic [1:0]                     s_axis_data_tready,
  input  logic [1:0]                     s_axis_data_tlast,
  input  logic [1:0]                     s_inverse,
  output logic [cfg_width(STAGE_NO)-1:0] fft_config_tdata,
  output logic [63:0]                    fft_s_data_tdata,
  output logic                           fft_s_data_tvalid,
  input  logic                           fft_s_data_tready,
  input  logic [63:0]                    fft_m_data_tdata,
  input  logic                           fft_m_data_tvalid,
  output logic                           fft_m_data_tready,
  input  logic                           fft_m_data_tlast,
  output logic [63:0]                    m_axis_data_tdata,
  output logic                           m_axis_data_tvalid,
  input  logic                           m_axis_data_tready,
  output logic                           m_axis_data_tlast,
  output logic                           m_axis_data_tuser,
  output logic                           event_tlast_unexpected,
  output logic                           event_tlast_missing
);

  localparam int              CW       = 2 * STAGE_NO;
  localparam logic [CW-1:0]   LAST_IDX = '1;
  localparam logic [0:0]      S_IDLE   = ST_IDLE;
  localparam logic [0:0]      S_LOAD   = ST_LOAD;

  logic [0:0]    state;
  logic          grant;
  logic          fwd;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic          next_grant;
  logic          push;
  logic          pop;
  logic          in_hs;
  logic          out_hs;
  logic          in_last;
  logic          out_last;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_head;
  sample_t       req_data;

  // The core's own end-of-frame marker is advisory; the counter-derived one is authoritative
  logic          unused_fft_tlast;
  assign unused_fft_tlast = fft_m_data_tlast;

  assign req_data = grant ? s_axis_data_tdata[127:64] : s_axis_data_tdata[63:0];
  assign push     = (state == S_IDLE) & (|s_axis_data_tvalid) & ~fifo_full;
  assign in_hs    = (state == S_LOAD) & s_axis_data_tvalid[grant] & fft_s_data_tready;
  assign in_last  = (in_cnt == LAST_IDX);

  // Round robin: with both requesting, pick the one not served last; grant holds the last winner
  always_comb begin
    next_grant = 1'b0;
    if (&s_axis_data_tvalid) next_grant = ~grant;
    else                     next_grant = s_axis_data_tvalid[1];
  end

  // Route the granted requester straight through to the FFT while loading
  always_comb begin
    s_axis_data_tready = 2'b00;
    fft_s_data_tvalid  = 1'b0;
    fft_s_data_tdata   = req_data;
    if (state == S_LOAD) begin
      fft_s_data_tvalid         = s_axis_data_tvalid[grant];
      s_axis_data_tready[grant] = fft_s_data_tready;
    end
  end

  assign event_tlast_unexpected = in_hs &  s_axis_data_tlast[grant] & ~in_last;
  assign event_tlast_missing    = in_hs & ~s_axis_data_tlast[grant] &  in_last;
  assign fft_config_tdata       = {{CW{1'b0}}, fwd};

  // Input FSM: arbitrate in IDLE, stream exactly N samples in LOAD; grant resets to 1 so 0 wins first
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= S_IDLE;
      grant  <= 1'b1;
      fwd    <= 1'b1;
      in_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (push) begin
        grant <= next_grant;
        fwd   <= ~s_inverse[next_grant];
        state <= S_LOAD;
      end
    end else if (in_hs) begin
      if (in_last) begin
        in_cnt <= '0;
        state  <= S_IDLE;
      end else begin
        in_cnt <= in_cnt + 1'b1;
      end
    end
  end

  // Results only flow while an owning frame id is queued
  assign m_axis_data_tvalid = fft_m_data_tvalid & ~fifo_empty;
  assign fft_m_data_tready  = m_axis_data_tready & ~fifo_empty;
  assign m_axis_data_tdata  = fft_m_data_tdata;
  assign out_hs             = m_axis_data_tvalid & m_axis_data_tready;
  assign out_last           = (out_cnt == LAST_IDX);
  assign m_axis_data_tlast  = ~fifo_empty & out_last;
  assign m_axis_data_tuser  = ~fifo_empty & fifo_head;
  assign pop                = out_hs & out_last;

  // Output counter regenerates frame boundaries from result handshakes
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_cnt <= '0;
    end else if (out_hs) begin
      out_cnt <= out_last ? '0 : out_cnt + 1'b1;
    end
  end

  k_fft_id_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_id_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (push),
    .din   (next_grant),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_k_fft_frame_sched.sv
// tb/tb_k_fft_frame_sched.sv - scoreboard bench for the FFT frame scheduler
module tb_k_fft_frame_sched;

  localparam int STAGE_NO = 3;
  localparam int N        = 64;
  localparam int DEPTH    = 4;

  typedef struct {
    bit inv;
    int tl_a;
    int tl_b;
  } job_t;

  typedef struct {
    logic [63:0] data;
    logic        user;
    logic        last;
  } exp_t;

  logic         aclk = 1'b0;
  logic         areset;
  logic [127:0] s_axis_data_tdata;
  logic [1:0]   s_axis_data_tvalid;
  logic [1:0]   s_axis_data_tready;
  logic [1:0]   s_axis_data_tlast;
  logic [1:0]   s_inverse;
  logic [6:0]   fft_config_tdata;
  logic [63:0]  fft_s_data_tdata;
  logic         fft_s_data_tvalid;
  logic         fft_s_data_tready;
  logic [63:0]  fft_m_data_tdata;
  logic         fft_m_data_tvalid;
  logic         fft_m_data_tready;
  logic         fft_m_data_tlast;
  logic [63:0]  m_axis_data_tdata;
  logic         m_axis_data_tvalid;
  logic         m_axis_data_tready;
  logic         m_axis_data_tlast;
  logic         m_axis_data_tuser;
  logic         event_tlast_unexpected;
  logic         event_tlast_missing;

  k_fft_frame_sched #(
    .STAGE_NO   (STAGE_NO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .aclk                   (aclk),
    .areset                 (areset),
    .s_axis_data_tdata      (s_axis_data_tdata),
    .s_axis_data_tvalid     (s_axis_data_tvalid),
    .s_axis_data_tready     (s_axis_data_tready),
    .s_axis_data_tlast      (s_axis_data_tlast),
    .s_inverse              (s_inverse),
    .fft_config_tdata       (fft_config_tdata),
    .fft_s_data_tdata       (fft_s_data_tdata),
    .fft_s_data_tvalid      (fft_s_data_tvalid),
    .fft_s_data_tready      (fft_s_data_tready),
    .fft_m_data_tdata       (fft_m_data_tdata),
    .fft_m_data_tvalid      (fft_m_data_tvalid),
    .fft_m_data_tready      (fft_m_data_tready),
    .fft_m_data_tlast       (fft_m_data_tlast),
    .m_axis_data_tdata      (m_axis_data_tdata),
    .m_axis_data_tvalid     (m_axis_data_tvalid),
    .m_axis_data_tready     (m_axis_data_tready),
    .m_axis_data_tlast      (m_axis_data_tlast),
    .m_axis_data_tuser      (m_axis_data_tuser),
    .event_tlast_unexpected (event_tlast_unexpected),
    .event_tlast_missing    (event_tlast_missing)
  );

  initial forever #5 aclk = ~aclk;

  int          n_cmp = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  int          exp_grant[$];
  job_t        jobs0[$];
  job_t        jobs1[$];
  bit          act[2];
  int          k[2];
  int          fid[2];
  job_t        cur[2];
  logic [1:0]  rv;
  logic [1:0]  rl;
  logic [1:0]  ri;
  logic [63:0] rd[2];
  int          fid_next = 0;
  int          frames_done = 0;
  int          rdy_mode = 0;
  bit          expect_blocked = 0;
  bit          drain_gate = 0;
  int          drain_base = 0;
  int          eu_cnt = 0;
  int          em_cnt = 0;
  bit          stall_en = 0;
  int          out_total = 0;
  int          fft_in_total = 0;

  assign s_axis_data_tvalid = rv;
  assign s_axis_data_tlast  = rl;
  assign s_inverse          = ri;
  assign s_axis_data_tdata  = {rd[1], rd[0]};

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic logic [63:0] sample_val(input int r, input int f, input int idx);
    return {8'(8'hA0 + r), 8'(f), 16'(idx), 32'(f * 4096 + idx * 3 + r)};
  endfunction

  // FFT core stand-in: one-cycle loopback queue, periodic input stalls, noisy core tlast
  logic [63:0] fq[$];
  logic [63:0] mdl_sdata;
  bit          mdl_shs;
  bit          mdl_mhs;
  int          mdl_cyc = 0;
  int          mdl_oidx = 0;
  initial begin
    fft_s_data_tready = 1'b1;
    fft_m_data_tvalid = 1'b0;
    fft_m_data_tdata  = '0;
    fft_m_data_tlast  = 1'b0;
    forever begin
      @(negedge aclk);
      #3;
      mdl_shs   = fft_s_data_tvalid && fft_s_data_tready;
      mdl_mhs   = fft_m_data_tvalid && fft_m_data_tready;
      mdl_sdata = fft_s_data_tdata;
      @(posedge aclk);
      #1;
      mdl_cyc++;
      if (areset) begin
        fq.delete();
      end else begin
        if (mdl_mhs) begin
          void'(fq.pop_front());
          mdl_oidx++;
        end
        if (mdl_shs) begin
          fq.push_back(mdl_sdata);
          fft_in_total++;
        end
      end
      fft_m_data_tvalid = (fq.size() > 0);
      fft_m_data_tdata  = (fq.size() > 0) ? fq[0] : 64'h0;
      fft_m_data_tlast  = (fq.size() > 0) && (mdl_oidx % 7 == 3);
      fft_s_data_tready = !(stall_en && (mdl_cyc % 5 == 4));
    end
  end

  // Monitor: pop the scoreboard on every consumer handshake
  exp_t mon_e;
  initial forever begin
    @(negedge aclk);
    #3;
    if (m_axis_data_tvalid && m_axis_data_tready) begin
      out_total++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL out_unexpected: got data %0h user %0b with no result expected", m_axis_data_tdata, m_axis_data_tuser);
      end else begin
        mon_e = sb.pop_front();
        check("out_tdata", m_axis_data_tdata, mon_e.data);
        check("out_tuser", 64'(m_axis_data_tuser), 64'(mon_e.user));
        check("out_tlast", 64'(m_axis_data_tlast), 64'(mon_e.last));
      end
    end
  end

  // Cycle runner: drives requesters, checks events/config/grant order, feeds the scoreboard
  // mode 0: until all idle and drained, 1: until frames_done >= arg, 2: fixed cycles, 3: until r0 index == arg
  task automatic run(input int max_cyc, input int mode, input int arg);
    bit   done;
    int   acc;
    logic eu;
    logic em;
    exp_t e;
    done = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge aclk);
      if (!act[0] && jobs0.size() > 0) begin
        cur[0] = jobs0.pop_front(); act[0] = 1; k[0] = 0; fid[0] = fid_next; fid_next++;
      end
      if (!act[1] && jobs1.size() > 0) begin
        cur[1] = jobs1.pop_front(); act[1] = 1; k[1] = 0; fid[1] = fid_next; fid_next++;
      end
      for (int r = 0; r < 2; r++) begin
        rv[r] = act[r];
        rd[r] = act[r] ? sample_val(r, fid[r], k[r]) : 64'h0;
        rl[r] = act[r] && (k[r] == cur[r].tl_a || k[r] == cur[r].tl_b);
        ri[r] = act[r] && cur[r].inv;
      end
      m_axis_data_tready = (rdy_mode == 1) || (rdy_mode == 2 && (c % 3 != 0));
      #3;
      acc = -1;
      for (int r = 0; r < 2; r++) if (act[r] && s_axis_data_tready[r]) acc = r;
      eu = 1'b0;
      em = 1'b0;
      if (acc >= 0) begin
        eu = rl[acc] && (k[acc] != N - 1);
        em = !rl[acc] && (k[acc] == N - 1);
      end
      check("ev_tlast_unexpected", 64'(event_tlast_unexpected), 64'(eu));
      check("ev_tlast_missing", 64'(event_tlast_missing), 64'(em));
      if (event_tlast_unexpected) eu_cnt++;
      if (event_tlast_missing) em_cnt++;
      if (expect_blocked) begin
        check("blocked_s_tready", 64'(s_axis_data_tready), 64'h0);
        check("blocked_fft_tvalid", 64'(fft_s_data_tvalid), 64'h0);
      end
      if (acc >= 0) begin
        if (k[acc] == 0) begin
          if (exp_grant.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_order: got requester %0d with no grant expected", acc);
          end else begin
            check("grant_order", 64'(acc), 64'(exp_grant.pop_front()));
          end
          if (drain_gate) begin
            check("drained_before_grant", 64'(out_total - drain_base >= N), 64'h1);
            drain_gate = 0;
          end
        end
        check("fft_config", 64'(fft_config_tdata), 64'({6'b0, ~cur[acc].inv}));
        e.data = rd[acc];
        e.user = 1'(acc);
        e.last = (k[acc] == N - 1);
        sb.push_back(e);
        k[acc]++;
        if (k[acc] == N) begin
          act[acc] = 0;
          frames_done++;
        end
      end
      case (mode)
        0: done = !act[0] && !act[1] && jobs0.size() == 0 && jobs1.size() == 0 && sb.size() == 0;
        1: done = (frames_done >= arg);
        3: done = act[0] && (k[0] == arg);
        default: done = 0;
      endcase
    end
    if (!done && mode != 2) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run_timeout: mode %0d got not-done after %0d cycles, required done", mode, max_cyc);
    end
  endtask

  // Assert reset at a falling edge, check outputs that same cycle, then release
  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    #3;
    check("rst_s_tready", 64'(s_axis_data_tready), 64'h0);
    check("rst_fft_s_tvalid", 64'(fft_s_data_tvalid), 64'h0);
    check("rst_fft_m_tready", 64'(fft_m_data_tready), 64'h0);
    check("rst_m_tvalid", 64'(m_axis_data_tvalid), 64'h0);
    check("rst_m_tlast", 64'(m_axis_data_tlast), 64'h0);
    check("rst_m_tuser", 64'(m_axis_data_tuser), 64'h0);
    check("rst_ev_unexpected", 64'(event_tlast_unexpected), 64'h0);
    check("rst_ev_missing", 64'(event_tlast_missing), 64'h0);
    check("rst_config", 64'(fft_config_tdata), 64'h01);
    rv = '0; rl = '0; ri = '0; rd[0] = '0; rd[1] = '0;
    act[0] = 0; act[1] = 0;
    jobs0.delete(); jobs1.delete(); exp_grant.delete(); sb.delete();
    frames_done = 0; expect_blocked = 0; drain_gate = 0; eu_cnt = 0; em_cnt = 0;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  int in_base;

  initial begin
    areset = 1'b1;
    rv = '0; rl = '0; ri = '0; rd[0] = '0; rd[1] = '0;
    m_axis_data_tready = 1'b0;
    repeat (2) @(posedge aclk);

    // Single forward frame from requester 0 with input stalls
    do_reset();
    stall_en = 1; rdy_mode = 1; in_base = fft_in_total;
    jobs0.push_back('{inv: 1'b0, tl_a: N - 1, tl_b: -1});
    exp_grant.push_back(0);
    run(3000, 0, 0);
    check("t1_fft_inputs", 64'(fft_in_total - in_base), 64'(N));
    check("t1_ev_unexpected_cnt", 64'(eu_cnt), 64'h0);
    check("t1_ev_missing_cnt", 64'(em_cnt), 64'h0);

    // Both requesters always valid: grants alternate, one inverse frame
    do_reset();
    stall_en = 1; rdy_mode = 2;
    jobs0.push_back('{inv: 1'b0, tl_a: N - 1, tl_b: -1});
    jobs0.push_back('{inv: 1'b0, tl_a: N - 1, tl_b: -1});
    jobs1.push_back('{inv: 1'b0, tl_a: N - 1, tl_b: -1});
    jobs1.push_back('{inv: 1'b1, tl_a: N - 1, tl_b: -1});
    exp_grant = '{0, 1, 0, 1};
    run(5000, 0, 0);
    check("t2_grants_left", 64'(exp_grant.size()), 64'h0);

    // Consumer stalled: FIFO fills at DEPTH frames, fifth frame waits for one drain
    do_reset();
    stall_en = 0; rdy_mode = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      jobs0.push_back('{inv: 1'b0, tl_a: N - 1, tl_b: -1});
      exp_grant.push_back(0);
    end
    run(2000, 1, DEPTH);
    expect_blocked = 1;
    run(30, 2, 0);
    expect_blocked = 0;
    drain_base = out_total;
    drain_gate = 1;
    rdy_mode = 1;
    run(5000, 0, 0);
    check("t3_fifth_granted", 64'(drain_gate), 64'h0);

    // Requester 1: early tlast at 10, none at 63
    do_reset();
    rdy_mode = 1;
    jobs1.push_back('{inv: 1'b0, tl_a: 10, tl_b: -1});
    exp_grant.push_back(1);
    run(3000, 0, 0);
    check("t4_ev_unexpected_cnt", 64'(eu_cnt), 64'h1);
    check("t4_ev_missing_cnt", 64'(em_cnt), 64'h1);

    // Reset mid-frame at sample 30, then fresh arbitration favours requester 0
    do_reset();
    rdy_mode = 1;
    jobs0.push_back('{inv: 1'b0, tl_a: N - 1, tl_b: -1});
    exp_grant.push_back(0);
    run(2000, 3, 30);
    do_reset();
    rdy_mode = 1;
    jobs0.push_back('{inv: 1'b0, tl_a: N - 1, tl_b: -1});
    jobs1.push_back('{inv: 1'b1, tl_a: N - 1, tl_b: -1});
    exp_grant = '{0, 1};
    run(4000, 0, 0);
    check("t5_grants_left", 64'(exp_grant.size()), 64'h0);
    check("t5_ev_unexpected_cnt", 64'(eu_cnt), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
